// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl
// Turns debounced per-player key strobes into a cursor position on the 9x10
// board and a two-click (source, destination) move request for the game-state
// block. The cursor and selection also drive the VGA renderer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   tick              100 Hz strobe; every key input is sampled only on tick
//   s_up/dn/lf/rt     short-press pulses (one step each)
//   l_up/dn/lf/rt     long-press levels (step on rise, then auto-repeat)
//   s_sel, s_cancel   select / cancel pulses
//   move_ready/ok     downstream handshake and verdict for the pending move
//   cur_x, cur_y      cursor column 0..8 / row 0..9
//   sel_valid/x/y     latched source square
//   move_valid        move request pending; src/dst stable while high
//   move_src/dst      {x,y} of source / destination
//   move_rejected     one-cycle pulse after a rejected move
module board_cursor_ctrl #(
  parameter int unsigned INIT_X       = 4,
  parameter int unsigned INIT_Y       = 9,
  parameter int unsigned REPEAT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       s_up,
  input  logic       s_dn,
  input  logic       s_lf,
  input  logic       s_rt,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       l_lf,
  input  logic       l_rt,
  input  logic       s_sel,
  input  logic       s_cancel,
  input  logic       move_ready,
  input  logic       move_ok,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       sel_valid,
  output logic [3:0] sel_x,
  output logic [3:0] sel_y,
  output logic       move_valid,
  output logic [7:0] move_src,
  output logic [7:0] move_dst,
  output logic       move_rejected
);

  localparam logic [3:0] INIT_X4 = 4'(INIT_X);
  localparam logic [3:0] INIT_Y4 = 4'(INIT_Y);
  localparam logic [3:0] REP4    = 4'(REPEAT_TICKS);
  localparam logic [3:0] MAX_X   = 4'd8;
  localparam logic [3:0] MAX_Y   = 4'd9;

  typedef enum logic [1:0] {IDLE, SELECTED, REQUEST} state_t;

  state_t     state_q, state_d;
  logic [3:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [3:0] sel_x_q, sel_x_d, sel_y_q, sel_y_d;
  logic       sel_valid_q, sel_valid_d;
  logic       move_valid_q, move_valid_d;
  logic [7:0] move_src_q, move_src_d, move_dst_q, move_dst_d;
  logic       move_rejected_q, move_rejected_d;
  logic [3:0] l_prev_q, l_prev_d;
  logic [3:0] rep_cnt_q, rep_cnt_d;

  // Direction bit order everywhere: {rt, lf, dn, up}
  logic [3:0] l_vec, s_vec, l_rise, step;
  logic       rep_fire;

  assign l_vec = {l_rt, l_lf, l_dn, l_up};
  assign s_vec = {s_rt, s_lf, s_dn, s_up};

  // Long-press edge detection and shared auto-repeat counter. Any edge of any
  // long level restarts the count; while something is held the counter fires
  // every REPEAT_TICKS ticks.
  always_comb begin
    l_rise    = l_vec & ~l_prev_q;
    l_prev_d  = l_prev_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (tick) begin
      l_prev_d = l_vec;
      if (l_vec != l_prev_q) begin
        rep_cnt_d = 4'd0;
      end else if (|l_vec) begin
        if (rep_cnt_q + 4'd1 == REP4) begin
          rep_cnt_d = 4'd0;
          rep_fire  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 4'd1;
        end
      end
    end
  end

  // Short and long of the same direction OR together: one step at most.
  assign step = tick ? (s_vec | l_rise | (l_vec & {4{rep_fire}})) : 4'd0;

  // Cursor: opposite directions cancel, edges saturate, frozen in REQUEST.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (state_q != REQUEST) begin
      if (step[3] && !step[2] && cur_x_q != MAX_X) cur_x_d = cur_x_q + 4'd1;
      if (step[2] && !step[3] && cur_x_q != 4'd0)  cur_x_d = cur_x_q - 4'd1;
      if (step[1] && !step[0] && cur_y_q != MAX_Y) cur_y_d = cur_y_q + 4'd1;
      if (step[0] && !step[1] && cur_y_q != 4'd0)  cur_y_d = cur_y_q - 4'd1;
    end
  end

  // Next-state logic. Select compares against the pre-move cursor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tick && s_sel && !s_cancel) state_d = SELECTED;
      end
      SELECTED: begin
        if (tick) begin
          if (s_cancel) state_d = IDLE;
          else if (s_sel) begin
            if (cur_x_q == sel_x_q && cur_y_q == sel_y_q) state_d = IDLE;
            else                                          state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (move_ready) state_d = move_ok ? IDLE : SELECTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    sel_x_d         = sel_x_q;
    sel_y_d         = sel_y_q;
    move_src_d      = move_src_q;
    move_dst_d      = move_dst_q;
    sel_valid_d     = (state_d != IDLE);
    move_valid_d    = (state_d == REQUEST);
    move_rejected_d = (state_q == REQUEST) && move_ready && !move_ok;
    if (state_q == IDLE && state_d == SELECTED) begin
      sel_x_d = cur_x_q;
      sel_y_d = cur_y_q;
    end
    if (state_d == IDLE) begin
      sel_x_d = 4'd0;
      sel_y_d = 4'd0;
    end
    if (state_q == SELECTED && state_d == REQUEST) begin
      move_src_d = {sel_x_q, sel_y_q};
      move_dst_d = {cur_x_q, cur_y_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cur_x_q         <= INIT_X4;
      cur_y_q         <= INIT_Y4;
      sel_x_q         <= 4'd0;
      sel_y_q         <= 4'd0;
      sel_valid_q     <= 1'b0;
      move_valid_q    <= 1'b0;
      move_src_q      <= 8'd0;
      move_dst_q      <= 8'd0;
      move_rejected_q <= 1'b0;
      l_prev_q        <= 4'd0;
      rep_cnt_q       <= 4'd0;
    end else begin
      state_q         <= state_d;
      cur_x_q         <= cur_x_d;
      cur_y_q         <= cur_y_d;
      sel_x_q         <= sel_x_d;
      sel_y_q         <= sel_y_d;
      sel_valid_q     <= sel_valid_d;
      move_valid_q    <= move_valid_d;
      move_src_q      <= move_src_d;
      move_dst_q      <= move_dst_d;
      move_rejected_q <= move_rejected_d;
      l_prev_q        <= l_prev_d;
      rep_cnt_q       <= rep_cnt_d;
    end
  end

  assign cur_x         = cur_x_q;
  assign cur_y         = cur_y_q;
  assign sel_valid     = sel_valid_q;
  assign sel_x         = sel_x_q;
  assign sel_y         = sel_y_q;
  assign move_valid    = move_valid_q;
  assign move_src      = move_src_q;
  assign move_dst      = move_dst_q;
  assign move_rejected = move_rejected_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Scoreboard bench for board_cursor_ctrl: the driver advances a reference
// model alongside the stimulus and queues expected snapshots / move requests /
// rejections; a negedge monitor pops and compares.
module tb_board_cursor_ctrl;
  localparam int REP = 8;

  logic clk = 0, rst = 0, tick = 0;
  logic s_up = 0, s_dn = 0, s_lf = 0, s_rt = 0;
  logic l_up = 0, l_dn = 0, l_lf = 0, l_rt = 0;
  logic s_sel = 0, s_cancel = 0, move_ready = 0, move_ok = 0;
  logic [3:0] cur_x, cur_y, sel_x, sel_y;
  logic       sel_valid, move_valid, move_rejected;
  logic [7:0] move_src, move_dst;

  always #5 clk = ~clk;

  board_cursor_ctrl #(.INIT_X(4), .INIT_Y(9), .REPEAT_TICKS(REP)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .s_up(s_up), .s_dn(s_dn), .s_lf(s_lf), .s_rt(s_rt),
    .l_up(l_up), .l_dn(l_dn), .l_lf(l_lf), .l_rt(l_rt),
    .s_sel(s_sel), .s_cancel(s_cancel),
    .move_ready(move_ready), .move_ok(move_ok),
    .cur_x(cur_x), .cur_y(cur_y), .sel_valid(sel_valid),
    .sel_x(sel_x), .sel_y(sel_y), .move_valid(move_valid),
    .move_src(move_src), .move_dst(move_dst), .move_rejected(move_rejected)
  );

  typedef struct {int cx; int cy; int sv; int sx; int sy; int mv;} snap_t;
  snap_t exp_q[$];
  int    exp_mv[$];   // src*256 + dst
  int    exp_rej[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 selected, 2 request.
  int m_cx = 4, m_cy = 9, m_mode = 0, m_sx = 0, m_sy = 0, m_cnt = 0;
  bit m_lp[4];

  function automatic int clamp(int v, int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  task automatic model_step();
    bit s[4], l[4], stp[4];
    bit any_edge, held, fire;
    int old;
    snap_t e;
    any_edge = 0; held = 0; fire = 0;
    for (int i = 0; i < 4; i++) stp[i] = 0;
    if (rst) begin
      m_cx = 4; m_cy = 9; m_mode = 0; m_sx = 0; m_sy = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_lp[i] = 0;
    end else begin
      old = m_mode;
      s[0] = s_up; s[1] = s_dn; s[2] = s_lf; s[3] = s_rt;
      l[0] = l_up; l[1] = l_dn; l[2] = l_lf; l[3] = l_rt;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (l[i] != m_lp[i]) any_edge = 1;
          if (l[i]) held = 1;
        end
        if (any_edge) m_cnt = 0;
        else if (held) begin
          m_cnt++;
          if (m_cnt == REP) begin m_cnt = 0; fire = 1; end
        end
        for (int i = 0; i < 4; i++) begin
          stp[i] = s[i] || (l[i] && !m_lp[i]) || (l[i] && fire);
          m_lp[i] = l[i];
        end
      end
      if (m_mode == 2) begin
        if (move_ready) begin
          if (move_ok) begin m_mode = 0; m_sx = 0; m_sy = 0; end
          else begin m_mode = 1; exp_rej.push_back(1); end
        end
      end else if (tick) begin
        if (m_mode == 0) begin
          if (s_sel && !s_cancel) begin m_mode = 1; m_sx = m_cx; m_sy = m_cy; end
        end else if (s_cancel) begin
          m_mode = 0; m_sx = 0; m_sy = 0;
        end else if (s_sel) begin
          if (m_cx == m_sx && m_cy == m_sy) begin m_mode = 0; m_sx = 0; m_sy = 0; end
          else begin
            m_mode = 2;
            exp_mv.push_back((m_sx * 16 + m_sy) * 256 + m_cx * 16 + m_cy);
          end
        end
      end
      if (tick && old != 2) begin
        m_cy = clamp(m_cy + int'(stp[1]) - int'(stp[0]), 9);
        m_cx = clamp(m_cx + int'(stp[3]) - int'(stp[2]), 8);
      end
    end
    e.cx = m_cx; e.cy = m_cy; e.sv = (m_mode != 0); e.sx = m_sx; e.sy = m_sy;
    e.mv = (m_mode == 2);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // One ticked cycle with the given short keys {rt,lf,dn,up}, then two quiet cycles.
  task automatic press(bit [3:0] s, bit sel, bit cancel);
    {s_rt, s_lf, s_dn, s_up} = s; s_sel = sel; s_cancel = cancel; tick = 1;
    cyc();
    {s_rt, s_lf, s_dn, s_up} = 4'd0; s_sel = 0; s_cancel = 0; tick = 0;
    cyc(); cyc();
  endtask

  task automatic do_rst();
    rst = 1; cyc(); rst = 0;
  endtask

  // Monitor
  bit   mv_prev = 0;
  int   held_src, held_dst;
  snap_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("cur_x", int'(cur_x), me.cx);
      chk("cur_y", int'(cur_y), me.cy);
      chk("sel_valid", int'(sel_valid), me.sv);
      chk("move_valid", int'(move_valid), me.mv);
      if (me.sv != 0) begin
        chk("sel_x", int'(sel_x), me.sx);
        chk("sel_y", int'(sel_y), me.sy);
      end
    end
    if (move_valid === 1'b1 && !mv_prev) begin
      if (exp_mv.size() == 0) chk("move_unexpected", 1, 0);
      else begin
        int v;
        v = exp_mv.pop_front();
        chk("move_src", int'(move_src), v / 256);
        chk("move_dst", int'(move_dst), v % 256);
      end
      held_src = int'(move_src); held_dst = int'(move_dst);
    end else if (move_valid === 1'b1) begin
      chk("move_src_stable", int'(move_src), held_src);
      chk("move_dst_stable", int'(move_dst), held_dst);
    end
    if (move_rejected === 1'b1) begin
      if (exp_rej.size() == 0) chk("rejected_unexpected", 1, 0);
      else void'(exp_rej.pop_front());
    end
    mv_prev = (move_valid === 1'b1);
  end

  initial begin
    do_rst();
    chk("rst_cur_x", int'(cur_x), 4);
    chk("rst_cur_y", int'(cur_y), 9);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_move_valid", int'(move_valid), 0);
    chk("rst_move_src", int'(move_src), 0);
    chk("rst_move_dst", int'(move_dst), 0);
    chk("rst_rejected", int'(move_rejected), 0);

    repeat (3) press(4'b0001, 0, 0);
    chk("up3_y", int'(cur_y), 6);
    repeat (12) press(4'b0100, 0, 0);
    chk("left_sat_x", int'(cur_x), 0);

    l_rt = 1;
    repeat (40) press(4'b0000, 0, 0);
    l_rt = 0;
    press(4'b0000, 0, 0);
    chk("long_rt_x", int'(cur_x), 5);

    // Accepted move (4,9) -> (4,7)
    do_rst();
    press(4'b0000, 1, 0);
    chk("sel_latched", int'(sel_valid), 1);
    press(4'b0001, 0, 0);
    press(4'b0001, 0, 0);
    press(4'b0000, 1, 0);
    chk("req_valid", int'(move_valid), 1);
    chk("req_src", int'(move_src), 8'h49);
    chk("req_dst", int'(move_dst), 8'h47);
    press(4'b0010, 0, 1);           // frozen cursor, cancel ignored
    chk("req_frozen_y", int'(cur_y), 7);
    move_ready = 1; move_ok = 1; cyc(); move_ready = 0; move_ok = 0;
    chk("ack_valid_low", int'(move_valid), 0);
    chk("ack_sel_clear", int'(sel_valid), 0);

    // Rejected move (4,7) -> (4,6)
    press(4'b0000, 1, 0);
    press(4'b0001, 0, 0);
    press(4'b0000, 1, 0);
    move_ready = 1; move_ok = 0; cyc(); move_ready = 0;
    chk("nack_pulse", int'(move_rejected), 1);
    cyc();
    chk("nack_pulse_end", int'(move_rejected), 0);
    chk("nack_sel_kept", int'(sel_valid), 1);
    press(4'b0001, 0, 0);
    chk("nack_movable_y", int'(cur_y), 5);

    // Cancel beats select; opposite directions cancel
    press(4'b0000, 1, 1);
    chk("cancel_idle", int'(sel_valid), 0);
    press(4'b0011, 0, 0);
    chk("updn_y", int'(cur_y), 5);

    // Reset during a pending request
    do_rst();
    press(4'b0000, 1, 0);
    press(4'b0001, 0, 0);
    press(4'b0000, 1, 0);
    rst = 1; cyc(); rst = 0;
    chk("rst_req_valid", int'(move_valid), 0);
    chk("rst_req_x", int'(cur_x), 4);
    chk("rst_req_y", int'(cur_y), 9);
    chk("rst_req_sel", int'(sel_valid), 0);
    void'(exp_mv.size());

    // Random phase
    for (int n = 0; n < 4000; n++) begin
      tick     = ($urandom % 4) == 0;
      s_up     = ($urandom % 6) == 0;
      s_dn     = ($urandom % 6) == 0;
      s_lf     = ($urandom % 6) == 0;
      s_rt     = ($urandom % 6) == 0;
      s_sel    = ($urandom % 7) == 0;
      s_cancel = ($urandom % 12) == 0;
      if (tick) begin
        if ($urandom % 12 == 0) l_up = ~l_up;
        if ($urandom % 12 == 0) l_dn = ~l_dn;
        if ($urandom % 12 == 0) l_lf = ~l_lf;
        if ($urandom % 12 == 0) l_rt = ~l_rt;
      end
      move_ready = ($urandom % 3) == 0;
      move_ok    = ($urandom % 2) == 0;
      rst        = ($urandom % 600) == 0;
      cyc();
    end
    rst = 0; tick = 0; move_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("snap_queue_drained", exp_q.size(), 0);
    chk("move_queue_drained", exp_mv.size(), 0);
    chk("rej_queue_drained", exp_rej.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
